// File: rtl/display_mode_sequencer_if.sv
// Bus bundle for display_mode_sequencer.
//   master : drives run/mask/dwell/image/force controls, observes the matrix drive
//   slave  : the sequencer; consumes controls, drives columns/active_mode/mode_switch
// Parameters must match those of the sequencer instance the bundle connects to.
interface display_mode_sequencer_if #(
   parameter int unsigned ROWS    = 7,
   parameter int unsigned COLS    = 3,
   parameter int unsigned MODES   = 2,
   parameter int unsigned DWELL_W = 16
) ();

   logic                        enable;
   logic [MODES-1:0]            mode_enable;
   logic [DWELL_W-1:0]          dwell_ticks;
   logic [MODES*COLS*ROWS-1:0]  images;
   logic                        force_valid;
   logic [1:0]                  force_mode;
   logic [COLS*ROWS-1:0]        columns;
   logic [1:0]                  active_mode;
   logic                        mode_switch;

   modport master (
      output enable, mode_enable, dwell_ticks, images, force_valid, force_mode,
      input  columns, active_mode, mode_switch
   );

   modport slave (
      input  enable, mode_enable, dwell_ticks, images, force_valid, force_mode,
      output columns, active_mode, mode_switch
   );

endinterface

// File: rtl/display_mode_sequencer.sv
// Cycles an LED matrix through up to four image sources, each shown for a
// programmable dwell time with an optional dark gap between sources.
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   bus.enable       run; low returns to IDLE
//   bus.mode_enable  per-source participation mask
//   bus.dwell_ticks  SHOW duration in cycles (0 behaves as 1)
//   bus.images       all source images, mode m col c row r at (m*COLS+c)*ROWS+r
//   bus.force_valid  one-cycle jump request to bus.force_mode
//   bus.columns      registered matrix drive, column c at c*ROWS+:ROWS
//   bus.active_mode  source currently shown (last shown while dark)
//   bus.mode_switch  one-cycle pulse on every SHOW entry
module display_mode_sequencer #(
   parameter int unsigned ROWS         = 7,
   parameter int unsigned COLS         = 3,
   parameter int unsigned MODES        = 2,
   parameter int unsigned DWELL_W      = 16,
   parameter int unsigned BLANK_CYCLES = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   display_mode_sequencer_if.slave   bus
);

   localparam int unsigned PIX_W   = COLS * ROWS;
   localparam int unsigned MODE_W  = 2;
   localparam int unsigned BLANK_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [MODE_W-1:0]    mode_q, mode_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [BLANK_W-1:0]   blank_q, blank_d;
   logic [PIX_W-1:0]     columns_q, columns_d;
   logic                 switch_q, switch_d;

   // First enabled mode above cur, wrapping; cur itself is the last candidate.
   // MSB of the result flags that any mode was found.
   function automatic logic [MODE_W:0] next_enabled(input logic [MODE_W-1:0] cur,
                                                    input logic [MODES-1:0]  mask);
      logic [MODES-1:0] shifted;
      logic [MODE_W:0]  res;
      int               idx;
      res = '0;
      // Walk offsets from farthest to nearest so the nearest hit wins.
      for (int i = int'(MODES); i >= 1; i--) begin
         idx     = (int'(cur) + i) % int'(MODES);
         shifted = mask >> idx;
         if (shifted[0]) begin
            res = {1'b1, MODE_W'(idx)};
         end
      end
      return res;
   endfunction

   logic [MODES-1:0]    mask;
   logic [MODES-1:0]    force_sel;
   logic [MODES-1:0]    active_sel;
   logic                force_ok;
   logic                active_en;
   logic [DWELL_W-1:0]  limit_m1;
   logic                expired;
   logic [MODE_W:0]     nxt;
   logic [MODE_W:0]     first;
   logic                blank_last;

   // Decoded conditions shared by the next-state logic.
   always_comb begin
      mask       = bus.mode_enable;
      force_sel  = mask >> bus.force_mode;
      active_sel = mask >> mode_q;
      force_ok   = bus.force_valid && (32'(bus.force_mode) < MODES) && force_sel[0];
      active_en  = active_sel[0];
      limit_m1   = (bus.dwell_ticks == '0) ? '0 : bus.dwell_ticks - DWELL_W'(1);
      // >= so a dwell shortened below the running count expires at once
      expired    = (dwell_q >= limit_m1);
      nxt        = next_enabled(mode_q, mask);
      first      = next_enabled(MODE_W'(MODES - 1), mask);
      blank_last = (blank_q == BLANK_W'(BLANK_CYCLES - 1));
   end

   // Next-state and output decode; enable, then force, then per-state rules.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      dwell_d  = '0;
      blank_d  = '0;
      switch_d = 1'b0;

      if (!bus.enable) begin
         state_d = IDLE;
      end else if (force_ok) begin
         state_d  = SHOW;
         mode_d   = bus.force_mode;
         switch_d = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (first[MODE_W]) begin
                  state_d  = SHOW;
                  mode_d   = first[MODE_W-1:0];
                  switch_d = 1'b1;
               end
            end
            SHOW: begin
               if (!active_en || (expired && nxt[MODE_W-1:0] != mode_q)) begin
                  if (BLANK_CYCLES == 0) begin
                     // No dark gap: resolve the next mode right away.
                     if (nxt[MODE_W]) begin
                        state_d  = SHOW;
                        mode_d   = nxt[MODE_W-1:0];
                        switch_d = 1'b1;
                     end else begin
                        state_d = IDLE;
                     end
                  end else begin
                     state_d = BLANK;
                  end
               end else if (expired) begin
                  // Sole enabled mode: restart the dwell without a pulse.
                  dwell_d = '0;
               end else begin
                  dwell_d = dwell_q + DWELL_W'(1);
               end
            end
            BLANK: begin
               if (blank_last) begin
                  // Mask is re-read here, so sources may come or go while dark.
                  if (nxt[MODE_W]) begin
                     state_d  = SHOW;
                     mode_d   = nxt[MODE_W-1:0];
                     switch_d = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  state_d = BLANK;
                  blank_d = blank_q + BLANK_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      // Image captured on the edge that lands in SHOW: one cycle of latency.
      columns_d = (state_d == SHOW) ? PIX_W'(bus.images >> (32'(mode_d) * PIX_W)) : '0;
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         mode_q    <= '0;
         dwell_q   <= '0;
         blank_q   <= '0;
         columns_q <= '0;
         switch_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         dwell_q   <= dwell_d;
         blank_q   <= blank_d;
         columns_q <= columns_d;
         switch_q  <= switch_d;
      end
   end

   assign bus.columns     = columns_q;
   assign bus.active_mode = mode_q;
   assign bus.mode_switch = switch_q;

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Bench for display_mode_sequencer: a 2-mode instance with a 2-cycle dark gap
// and a 4-mode instance with no gap, each tracked by a behavioural model.
module tb_display_mode_sequencer;

   localparam int unsigned ROWS = 7;
   localparam int unsigned COLS = 3;
   localparam int unsigned DW   = 16;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   display_mode_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .MODES(2), .DWELL_W(DW)) ifa ();
   display_mode_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .MODES(4), .DWELL_W(DW)) ifb ();

   display_mode_sequencer #(.ROWS(ROWS), .COLS(COLS), .MODES(2), .DWELL_W(DW), .BLANK_CYCLES(2))
      dut_a (.clock(clock), .reset(reset), .bus(ifa.slave));

   display_mode_sequencer #(.ROWS(ROWS), .COLS(COLS), .MODES(4), .DWELL_W(DW), .BLANK_CYCLES(0))
      dut_b (.clock(clock), .reset(reset), .bus(ifb.slave));

   int checks = 0;
   int errors = 0;

   // Model: a source is either lit, counting down dark cycles, or idle.
   bit          m_show [2];
   int          m_left [2];
   int          m_mode [2];
   int          m_el   [2];
   logic [20:0] e_cols [2];
   logic [1:0]  e_mode [2];
   logic        e_sw   [2];

   function automatic logic bit_of(input logic [3:0] mask, input int idx);
      logic [3:0] t;
      t = mask >> idx;
      return t[0];
   endfunction

   function automatic int next_en(input int cur, input logic [3:0] mask, input int n);
      for (int k = 1; k <= n; k++) begin
         int c;
         c = (cur + k) % n;
         if (bit_of(mask, c)) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_show[i] = 0; m_left[i] = 0; m_mode[i] = 0; m_el[i] = 0;
         e_cols[i] = '0; e_mode[i] = '0; e_sw[i] = 1'b0;
      end
   endtask

   task automatic show_enter(input int id, input int md);
      m_show[id] = 1; m_left[id] = 0; m_mode[id] = md; m_el[id] = 0; e_sw[id] = 1'b1;
   endtask

   task automatic blank_done(input int id, input int n, input logic [3:0] mask);
      int nx;
      nx = next_en(m_mode[id], mask, n);
      if (nx >= 0) show_enter(id, nx);
   endtask

   task automatic leave_show(input int id, input int n, input int nb, input logic [3:0] mask);
      m_show[id] = 0;
      m_el[id]   = 0;
      if (nb == 0) blank_done(id, n, mask);
      else m_left[id] = nb;
   endtask

   task automatic model_step(input int id, input int n, input int nb, input logic en,
                             input logic [3:0] mask, input logic [15:0] dwell,
                             input logic [83:0] img, input logic fv, input logic [1:0] fm);
      int lim, nx;
      e_sw[id] = 1'b0;
      if (!en) begin
         m_show[id] = 0; m_left[id] = 0; m_el[id] = 0;
      end else if (fv && int'(fm) < n && bit_of(mask, int'(fm))) begin
         show_enter(id, int'(fm));
      end else if (m_show[id]) begin
         lim = (dwell == 16'd0) ? 1 : int'(dwell);
         if (!bit_of(mask, m_mode[id])) begin
            leave_show(id, n, nb, mask);
         end else if (m_el[id] + 1 >= lim) begin
            nx = next_en(m_mode[id], mask, n);
            if (nx != m_mode[id]) leave_show(id, n, nb, mask);
            else m_el[id] = 0;
         end else begin
            m_el[id]++;
         end
      end else if (m_left[id] > 0) begin
         m_left[id]--;
         if (m_left[id] == 0) blank_done(id, n, mask);
      end else if (mask != 4'd0) begin
         show_enter(id, next_en(n - 1, mask, n));
      end
      e_cols[id] = m_show[id] ? 21'(img >> (m_mode[id] * 21)) : 21'd0;
      e_mode[id] = 2'(m_mode[id]);
   endtask

   // One clock: models consume the inputs present at the edge.
   task automatic step();
      @(posedge clock);
      if (reset) begin
         model_reset();
      end else begin
         model_step(0, 2, 2, ifa.enable, 4'(ifa.mode_enable), ifa.dwell_ticks,
                    84'(ifa.images), ifa.force_valid, ifa.force_mode);
         model_step(1, 4, 0, ifb.enable, ifb.mode_enable, ifb.dwell_ticks,
                    ifb.images, ifb.force_valid, ifb.force_mode);
      end
      #1;
   endtask

   task automatic go_idle();
      ifa.enable = 1'b0; ifa.force_valid = 1'b0;
      ifb.enable = 1'b0; ifb.force_valid = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ifa.enable = 1'b1; ifa.mode_enable = 2'b11; ifa.dwell_ticks = 16'd4;
      ifa.images = 42'({$urandom, $urandom}); ifa.force_valid = 1'b0; ifa.force_mode = 2'd0;
      ifb.enable = 1'b1; ifb.mode_enable = 4'hF; ifb.dwell_ticks = 16'd2;
      ifb.images = 84'({$urandom, $urandom, $urandom}); ifb.force_valid = 1'b0; ifb.force_mode = 2'd0;
      model_reset();
      #3;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (ifa.columns !== 21'd0 || ifa.active_mode !== 2'd0 || ifa.mode_switch !== 1'b0 ||
             ifb.columns !== 21'd0 || ifb.active_mode !== 2'd0 || ifb.mode_switch !== 1'b0) begin
            errors++;
            $display("FAIL reset c%0d: a=%h/%0d/%b b=%h/%0d/%b required all zero", c,
                     ifa.columns, ifa.active_mode, ifa.mode_switch,
                     ifb.columns, ifb.active_mode, ifb.mode_switch);
         end
         step();
      end
      #3 reset = 1'b0;
   endtask

   task automatic test_rotation();
      int pulses = 0;
      go_idle();
      ifa.mode_enable = 2'b11; ifa.dwell_ticks = 16'd4; ifa.enable = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         ifa.images = 42'({$urandom, $urandom});
         step();
         checks++;
         if (ifa.columns !== e_cols[0] || ifa.active_mode !== e_mode[0] || ifa.mode_switch !== e_sw[0]) begin
            errors++;
            $display("FAIL rotation c%0d: got %h/%0d/%b required %h/%0d/%b", c, ifa.columns,
                     ifa.active_mode, ifa.mode_switch, e_cols[0], e_mode[0], e_sw[0]);
         end
         if (ifa.mode_switch === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 4) begin
         errors++;
         $display("FAIL rotation_pulses: got %0d required 4", pulses);
      end
   endtask

   task automatic test_single();
      int pulses = 0;
      int dark = 0;
      go_idle();
      ifa.mode_enable = 2'b01; ifa.dwell_ticks = 16'd3; ifa.images = '1; ifa.enable = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         checks++;
         if (ifa.columns !== e_cols[0] || ifa.active_mode !== e_mode[0] || ifa.mode_switch !== e_sw[0]) begin
            errors++;
            $display("FAIL single c%0d: got %h/%0d/%b required %h/%0d/%b", c, ifa.columns,
                     ifa.active_mode, ifa.mode_switch, e_cols[0], e_mode[0], e_sw[0]);
         end
         if (ifa.mode_switch === 1'b1) pulses++;
         if (ifa.columns !== 21'h1FFFFF) dark++;
      end
      checks++;
      if (pulses !== 1 || dark !== 0) begin
         errors++;
         $display("FAIL single_pulse_dark: got pulses=%0d dark=%0d required 1 and 0", pulses, dark);
      end
   endtask

   task automatic test_wrap();
      int bad = 0;
      int wrapped = 0;
      int prev = -1;
      go_idle();
      ifb.mode_enable = 4'b1010; ifb.dwell_ticks = 16'd2; ifb.enable = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         ifb.images = 84'({$urandom, $urandom, $urandom});
         step();
         checks++;
         if (ifb.columns !== e_cols[1] || ifb.active_mode !== e_mode[1] || ifb.mode_switch !== e_sw[1]) begin
            errors++;
            $display("FAIL wrap c%0d: got %h/%0d/%b required %h/%0d/%b", c, ifb.columns,
                     ifb.active_mode, ifb.mode_switch, e_cols[1], e_mode[1], e_sw[1]);
         end
         if (ifb.mode_switch === 1'b1) begin
            if (ifb.active_mode !== 2'd1 && ifb.active_mode !== 2'd3) bad++;
            if (prev == 3 && ifb.active_mode === 2'd1) wrapped = 1;
            prev = int'(ifb.active_mode);
         end
      end
      checks++;
      if (bad !== 0 || wrapped !== 1) begin
         errors++;
         $display("FAIL wrap_order: got bad=%0d wrapped=%0d required 0 and 1", bad, wrapped);
      end
   endtask

   task automatic test_force_expiry();
      logic [41:0] img;
      img = 42'({$urandom, $urandom});
      go_idle();
      ifa.mode_enable = 2'b11; ifa.dwell_ticks = 16'd4; ifa.images = img; ifa.enable = 1'b1;
      for (int c = 1; c <= 4; c++) step();
      ifa.force_valid = 1'b1; ifa.force_mode = 2'd1;
      step();
      ifa.force_valid = 1'b0;
      checks++;
      if (ifa.active_mode !== 2'd1 || ifa.mode_switch !== 1'b1 || ifa.columns !== 21'(img >> 21)) begin
         errors++;
         $display("FAIL force_expiry: got %h/%0d/%b required %h/1/1", ifa.columns,
                  ifa.active_mode, ifa.mode_switch, 21'(img >> 21));
      end
      for (int c = 6; c <= 9; c++) begin
         step();
         checks++;
         if (ifa.columns !== e_cols[0] || ifa.active_mode !== e_mode[0] || ifa.mode_switch !== e_sw[0]) begin
            errors++;
            $display("FAIL force_follow c%0d: got %h/%0d/%b required %h/%0d/%b", c, ifa.columns,
                     ifa.active_mode, ifa.mode_switch, e_cols[0], e_mode[0], e_sw[0]);
         end
         if (c == 8) begin
            checks++;
            if (ifa.columns !== 21'(img >> 21)) begin
               errors++;
               $display("FAIL force_dwell: got %h required %h", ifa.columns, 21'(img >> 21));
            end
         end
      end
      checks++;
      if (ifa.columns !== 21'd0) begin
         errors++;
         $display("FAIL force_blank: got %h required 0", ifa.columns);
      end
   endtask

   task automatic test_dwell0_drop();
      logic [41:0] img;
      img = 42'({$urandom, $urandom});
      go_idle();
      ifa.mode_enable = 2'b11; ifa.dwell_ticks = 16'd0; ifa.images = img; ifa.enable = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c == 4) ifa.mode_enable = 2'b01;
         checks++;
         if (ifa.columns !== e_cols[0] || ifa.active_mode !== e_mode[0] || ifa.mode_switch !== e_sw[0]) begin
            errors++;
            $display("FAIL dwell0 c%0d: got %h/%0d/%b required %h/%0d/%b", c, ifa.columns,
                     ifa.active_mode, ifa.mode_switch, e_cols[0], e_mode[0], e_sw[0]);
         end
         if (c == 5) begin
            checks++;
            if (ifa.columns !== 21'd0 || ifa.active_mode !== 2'd1) begin
               errors++;
               $display("FAIL drop_blank: got %h/%0d required 0/1", ifa.columns, ifa.active_mode);
            end
         end
         if (c == 7) begin
            checks++;
            if (ifa.active_mode !== 2'd0 || ifa.mode_switch !== 1'b1 || ifa.columns !== 21'(img)) begin
               errors++;
               $display("FAIL drop_next: got %h/%0d/%b required %h/0/1", ifa.columns,
                        ifa.active_mode, ifa.mode_switch, 21'(img));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [41:0] img;
      img = 42'({$urandom, $urandom});
      go_idle();
      ifa.mode_enable = 2'b11; ifa.dwell_ticks = 16'd4; ifa.images = img; ifa.enable = 1'b1;
      // Cycle 11 is dark after mode 1; cycle 7 (after release) is mode 1 lit.
      for (int phase = 0; phase < 2; phase++) begin
         for (int c = 1; c <= (phase == 0 ? 11 : 6); c++) step();
         #2 reset = 1'b1;
         #1;
         checks++;
         if (ifa.columns !== 21'd0 || ifa.active_mode !== 2'd0 || ifa.mode_switch !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid p%0d: got %h/%0d/%b required 0/0/0", phase, ifa.columns,
                     ifa.active_mode, ifa.mode_switch);
         end
         model_reset();
         #1 reset = 1'b0;
         step();
         checks++;
         if (ifa.active_mode !== 2'd0 || ifa.mode_switch !== 1'b1 || ifa.columns !== 21'(img)) begin
            errors++;
            $display("FAIL reset_resume p%0d: got %h/%0d/%b required %h/0/1", phase, ifa.columns,
                     ifa.active_mode, ifa.mode_switch, 21'(img));
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         ifa.enable      = ($urandom_range(0, 49) != 0);
         ifb.enable      = ($urandom_range(0, 49) != 0);
         if ($urandom_range(0, 9) == 0) ifa.mode_enable = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) ifb.mode_enable = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) ifa.dwell_ticks = 16'($urandom_range(0, 6));
         if ($urandom_range(0, 19) == 0) ifb.dwell_ticks = 16'($urandom_range(0, 6));
         ifa.images      = 42'({$urandom, $urandom});
         ifb.images      = 84'({$urandom, $urandom, $urandom});
         ifa.force_valid = ($urandom_range(0, 9) == 0);
         ifb.force_valid = ($urandom_range(0, 9) == 0);
         ifa.force_mode  = 2'($urandom_range(0, 3));
         ifb.force_mode  = 2'($urandom_range(0, 3));
         step();
         checks++;
         if (ifa.columns !== e_cols[0] || ifa.active_mode !== e_mode[0] || ifa.mode_switch !== e_sw[0]) begin
            errors++;
            $display("FAIL random_a c%0d: got %h/%0d/%b required %h/%0d/%b", c, ifa.columns,
                     ifa.active_mode, ifa.mode_switch, e_cols[0], e_mode[0], e_sw[0]);
         end
         checks++;
         if (ifb.columns !== e_cols[1] || ifb.active_mode !== e_mode[1] || ifb.mode_switch !== e_sw[1]) begin
            errors++;
            $display("FAIL random_b c%0d: got %h/%0d/%b required %h/%0d/%b", c, ifb.columns,
                     ifb.active_mode, ifb.mode_switch, e_cols[1], e_mode[1], e_sw[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_single();
      test_wrap();
      test_force_expiry();
      test_dwell0_drop();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
